// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receive path.
package uart_pkg;

    // Parity modes; the fourth encoding also means no parity.
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Oversampling: 16 ticks per bit, majority of samples 7/8/9.
    localparam int         OS_RATE  = 16;
    localparam logic [3:0] SMP_A    = 4'd7;
    localparam logic [3:0] SMP_B    = 4'd8;
    localparam logic [3:0] SMP_C    = 4'd9;
    localparam logic [3:0] SMP_LAST = 4'(OS_RATE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    // Two-of-three vote across the mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; drops pushes when full unless a pop frees a slot.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign head_valid = (count != '0);
    assign full       = (count == (AW + 1)'(DEPTH));
    assign pop_ok     = pop && head_valid;
    assign push_ok    = push && (!full || pop_ok);
    assign drop       = push && full && !pop_ok;
    // Head reads as zero while empty so stale storage never shows.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with runtime framing and a flagged receive FIFO.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_en,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [3:0]                    data_len,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_BITS-1:0]          out_data,
    output logic                          out_perr,
    output logic                          out_ferr,
    output logic                          out_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overrun
);
    localparam int         FW      = DATA_BITS + 3;
    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'(DATA_BITS);

    // Out-of-range lengths fall back to the widest supported frame.
    function automatic logic [3:0] clamp_len(input logic [3:0] dl);
        if (dl < LEN_MIN || dl > LEN_MAX) return LEN_MAX;
        return dl;
    endfunction

    logic                 rx_p0, rxs, rxs_d;
    rx_state_t            state, state_d;
    logic [DIV_W-1:0]     div_eff, presc;
    logic [3:0]           s_cnt, bit_cnt, len_q;
    logic [1:0]           par_q;
    logic                 two_q, par_en;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q, ferr_q, zero_q;
    logic                 v7, v8, bit_val;
    logic                 tick, smp_res, bit_end, start_det;
    logic                 push, fifo_drop;
    logic [FW-1:0]        push_word, head_word;

    assign div_eff   = (divisor == '0) ? DIV_W'(1) : divisor;
    assign tick      = (state != ST_IDLE) && (presc >= div_eff - DIV_W'(1));
    assign smp_res   = tick && (s_cnt == SMP_C);
    assign bit_end   = tick && (s_cnt == SMP_LAST);
    assign start_det = rx_en && rxs_d && !rxs;
    assign bit_val   = maj3(v7, v8, rxs);
    assign par_en    = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign busy      = (state != ST_IDLE);
    // Final stop bit folds straight into the pushed flags.
    assign push_word = {shreg, perr_q, ferr_q | ~bit_val, zero_q & ~bit_val};

    // ---- stage: 2-flop synchroniser and edge history, idle-high ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rxs   <= rx_p0;
            rxs_d <= rxs;
        end
    end

    // ---- stage: frame FSM state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next-state decode; push fires on the resolving tick of the last stop bit.
    always_comb begin
        state_d = state;
        push    = 1'b0;
        case (state)
            ST_IDLE:   if (start_det) state_d = ST_START;
            ST_START: begin
                if (smp_res && bit_val) state_d = ST_IDLE;
                else if (bit_end)       state_d = ST_DATA;
            end
            ST_DATA:   if (bit_end && bit_cnt == len_q - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (bit_end) state_d = ST_STOP1;
            ST_STOP1: begin
                if (!two_q && smp_res) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else if (two_q && bit_end) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (smp_res) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Prescaler, sample index, frame config latch and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            s_cnt   <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
            par_q   <= '0;
            two_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= fifo_drop;
            if (state == ST_IDLE) begin
                presc <= '0;
                s_cnt <= '0;
                if (start_det) begin
                    len_q   <= clamp_len(data_len);
                    par_q   <= parity_mode;
                    two_q   <= two_stop;
                    bit_cnt <= '0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                    zero_q  <= 1'b1;
                end
            end else begin
                presc <= tick ? '0 : presc + DIV_W'(1);
                if (tick) s_cnt <= s_cnt + 4'd1;
                if (smp_res) begin
                    zero_q <= zero_q & ~bit_val;
                    if (state == ST_PARITY)
                        perr_q <= bit_val != ((^shreg) ^ (par_q == PAR_ODD));
                    if (state == ST_STOP1 || state == ST_STOP2)
                        ferr_q <= ferr_q | ~bit_val;
                end
                if (bit_end && state == ST_DATA) bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // ---- stage: mid-bit samples and data shift register (no reset) ----
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            shreg <= '0;
        end else begin
            if (tick && s_cnt == SMP_A) v7 <= rxs;
            if (tick && s_cnt == SMP_B) v8 <= rxs;
            if (smp_res && state == ST_DATA)
                shreg <= shreg | (DATA_BITS'(bit_val) << bit_cnt);
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_word),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_data  (head_word),
        .count      (fifo_count),
        .drop       (fifo_drop)
    );

    assign {out_data, out_perr, out_ferr, out_brk} = head_word;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framing formats, glitches, break, overrun, reset.
module tb_uart_rx_os;
    localparam int DATA_BITS  = 8;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV        = 4;
    localparam int BIT        = 16 * DIV;

    logic                 clk = 1'b0;
    logic                 rst, rx_en, rx, two_stop, out_ready;
    logic [DIV_W-1:0]     divisor;
    logic [3:0]           data_len;
    logic [1:0]           parity_mode;
    logic                 out_valid, out_perr, out_ferr, out_brk, busy, overrun;
    logic [DATA_BITS-1:0] out_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ovr_base;

    uart_rx_os #(
        .DATA_BITS  (DATA_BITS),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rx          (rx),
        .divisor     (divisor),
        .data_len    (data_len),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_perr    (out_perr),
        .out_ferr    (out_ferr),
        .out_brk     (out_brk),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun) ovr_cnt++;

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; glitch_bit >= 0 puts a 1-tick inverted spike on that data bit's s=8 sample.
    task automatic send_frame(input logic [8:0] d, input int len, input int pm, input bit two,
                              input bit flip_par, input bit stop_v, input int glitch_bit);
        logic [15:0] seq;
        logic        p;
        int          nb;
        data_len    = 4'(len);
        parity_mode = 2'(pm);
        two_stop    = two;
        seq = '0;
        p   = 1'b0;
        for (int i = 0; i < len; i++) begin
            seq[1+i] = d[i];
            p        = p ^ d[i];
        end
        nb = 1 + len;
        if (pm == 1 || pm == 2) begin
            if (pm == 2) p = ~p;
            if (flip_par) p = ~p;
            seq[nb] = p;
            nb++;
        end
        seq[nb] = stop_v;
        nb++;
        if (two) begin
            seq[nb] = 1'b1;
            nb++;
        end
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = seq[i];
            if (i == glitch_bit + 1) begin
                repeat (34) @(negedge clk);
                rx = ~seq[i];
                repeat (4) @(negedge clk);
                rx = seq[i];
                repeat (BIT - 38) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe,
                             input logic fe, input logic bk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_perr"},  32'(out_perr),  32'(pe));
        check({tag, "_ferr"},  32'(out_ferr),  32'(fe));
        check({tag, "_brk"},   32'(out_brk),   32'(bk));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; divisor = DIV_W'(DIV);
        data_len = 4'd8; parity_mode = 2'd0; two_stop = 1'b0; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        idle(8);

        // 8N1 0xA5 with exact valid-rise timing: stop starts 576 cycles in, s=9 tick at 618.
        fork
            send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, -1);
            begin
                @(negedge clk);
                repeat (618) @(negedge clk);
                check("t1_valid_pre", 32'(out_valid), 32'd0);
                @(negedge clk);
                check("t1_valid_rise", 32'(out_valid), 32'd1);
            end
        join
        idle(BIT / 2);
        check("t1_count", 32'(fifo_count), 32'd1);
        pop_check("t1", 8'hA5, 1'b0, 1'b0, 1'b0);

        // 7E2 0x35 with flipped parity bit.
        send_frame(9'h035, 7, 1, 1'b1, 1'b1, 1'b1, -1);
        idle(BIT / 2);
        pop_check("t2", 8'h35, 1'b1, 1'b0, 1'b0);

        // 8O1 0xC3 with correct parity.
        send_frame(9'h0C3, 8, 2, 1'b0, 1'b0, 1'b1, -1);
        idle(BIT / 2);
        pop_check("t2o", 8'hC3, 1'b0, 1'b0, 1'b0);

        // 2-tick low pulse on idle line is a false start.
        @(negedge clk);
        rx = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("t3_busy_hi", 32'(busy), 32'd1);
        repeat (2 * BIT) @(negedge clk);
        check("t3_busy_lo", 32'(busy), 32'd0);
        check("t3_count", 32'(fifo_count), 32'd0);

        // 1-tick spike on data bit 2 at s=8 is outvoted.
        send_frame(9'h05A, 8, 0, 1'b0, 1'b0, 1'b1, 2);
        idle(BIT / 2);
        pop_check("t3g", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Stop bit driven low.
        send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1'b0, -1);
        idle(BIT / 2);
        pop_check("t4f", 8'h3C, 1'b0, 1'b1, 1'b0);

        // Line held low for 12 bit times: one break entry only.
        @(negedge clk);
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("t4b_count_low", 32'(fifo_count), 32'd1);
        idle(2 * BIT);
        check("t4b_count_high", 32'(fifo_count), 32'd1);
        check("t4b_busy", 32'(busy), 32'd0);
        pop_check("t4b", 8'h00, 1'b0, 1'b1, 1'b1);

        // Overrun: nine frames into an eight-entry FIFO.
        ovr_base = ovr_cnt;
        for (int i = 1; i <= 9; i++) begin
            send_frame(9'(i), 8, 0, 1'b0, 1'b0, 1'b1, -1);
            idle(8);
        end
        idle(BIT / 2);
        check("t5_count", 32'(fifo_count), 32'd8);
        check("t5_overrun", 32'(ovr_cnt - ovr_base), 32'd1);
        for (int i = 1; i <= 8; i++) pop_check("t5_drain", 8'(i), 1'b0, 1'b0, 1'b0);
        check("t5_empty", 32'(out_valid), 32'd0);

        // Reset in data bit 3 of 0x55 with two entries queued.
        send_frame(9'h011, 8, 0, 1'b0, 1'b0, 1'b1, -1);
        idle(8);
        send_frame(9'h022, 8, 0, 1'b0, 1'b0, 1'b1, -1);
        idle(BIT / 2);
        check("t6_queued", 32'(fifo_count), 32'd2);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            rx = (b % 2 == 0) ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        idle(BIT);
        send_frame(9'h081, 8, 0, 1'b0, 1'b0, 1'b1, -1);
        idle(BIT / 2);
        check("t6_count_after", 32'(fifo_count), 32'd1);
        pop_check("t6", 8'h81, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised UART receiver; next generation of the team's fixed 8N1 RX path.
- Adds 16x oversampling with 3-sample majority vote and a runtime baud divisor.
- Adds runtime data/parity/stop format and a receive FIFO with per-entry error flags.
- Sits between the pad-side rx line and the APB register block, which drains the FIFO and reads status.

Parameters:
- DATA_BITS, 8, maximum data-field width; legal 5..9.
- DIV_W, 16, width of the oversample divisor input.
- FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_en  in  1  receiver enable; gates start detection only.
- rx  in  1  asynchronous serial input, idle high.
- divisor  in  DIV_W  clocks per oversample tick; 0 is treated as 1.
- data_len  in  4  runtime data bits, 5..DATA_BITS; out-of-range values clamp to DATA_BITS.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 none.
- two_stop  in  1  1 = check two stop bits.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- out_data  out  DATA_BITS  head data, LSB = first received bit, unused MSBs zero.
- out_perr  out  1  head parity error.
- out_ferr  out  1  head framing error.
- out_brk  out  1  head is a break: all data 0, parity 0 or absent, stop 0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - rx synchroniser: 1.
  - All outputs: 0.
  - FIFO: empty.
  - FSM: IDLE.
  - Prescaler and sample counters: 0.
- rx passes through a 2-flop synchroniser. All logic uses the synchronised value rxs.
- Prescaler:
  - Counts 0..max(divisor,1)-1 and pulses tick on wrap.
  - Runs only while not IDLE; cleared on entry to START.
  - One bit period = 16 ticks; sample index s = 0..15.
- Majority vote: bit value = majority of rxs captured at ticks s=7,8,9. The bit is resolved on the s=9 tick.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE -> START:
  - Condition: rx_en=1 and a falling edge on rxs (previous 1, current 0).
  - On entry, latch data_len, parity_mode and two_stop. Input changes mid-frame have no effect.
- START:
  - Resolved bit 1 -> IDLE (false start, nothing pushed).
  - Resolved bit 0 -> DATA at s=15.
- DATA:
  - Shift in latched-data_len bits, LSB first.
  - Then go to PARITY if parity is enabled, else STOP1.
- PARITY:
  - Computed parity = XOR of data bits, inverted for odd.
  - perr = received parity bit != computed parity.
- STOP1:
  - Resolved 0 sets ferr.
  - If two_stop, go to STOP2; else finish at s=9.
- STOP2: resolved 0 also sets ferr; finish at s=9.
- Finish:
  - Push {data, perr, ferr, brk} in the same cycle, then return to IDLE.
  - A start edge is accepted from the next cycle, so back-to-back frames lose no time.
- rx_en deasserted mid-frame: the frame completes and is pushed; only new starts are blocked.
- FIFO:
  - Synchronous, first-word fall-through. out_valid is high in the cycle after the first push into an empty FIFO.
  - Push when full with no pop in the same cycle: frame dropped, overrun=1 for one cycle, contents unchanged.
  - Push and pop in the same cycle when full: both take effect, count unchanged.
  - Push and pop in the same cycle when empty: the push is stored; the pop is ignored because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- rst=1 in any cycle, including mid-frame: all state returns to reset values on the next edge. FIFO contents are discarded.

Decomposition:
- Shared package uart_pkg holds:
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - RX state enum.
  - OS_RATE=16 and sample indices 7/8/9.
- One natural sub-module, uart_rx_fifo:
  - Parametrised width and depth, FWFT, synchronous active-high reset.
  - Instantiated with width DATA_BITS+3.
- Synchroniser, prescaler and FSM stay in uart_rx_os.

Test Plan:
1. 8N1 nominal: divisor=4, data_len=8, parity_mode=0, send 0xA5 -> one entry 0xA5, perr=0, ferr=0, brk=0; out_valid rises 1 cycle after the s=9 tick of stop.
2. 7E2 with parity fault: data_len=7, parity_mode=1, two_stop=1, send 0x35 with the parity bit flipped -> out_data=0x35, perr=1, ferr=0.
3. Glitch rejection:
   - Inject a 2-tick low pulse on idle rx -> nothing pushed, busy returns to 0.
   - Inject a 1-tick spike inside a data bit at s=8 -> majority vote yields the correct byte.
4. Framing and break:
   - Stop bit driven 0 on 0x3C -> ferr=1.
   - Line held low for 12 bit times -> one entry 0x00 with ferr=1, brk=1, and no further frames until rx returns high and falls again.
5. Overrun: DEPTH=8, out_ready=0, send 9 frames 0x01..0x09 -> fifo_count=8 and overrun pulses once on frame 9. Then drain with out_ready=1 -> 0x01..0x08 in order.
6. Reset mid-frame: assert rst at data bit 3 of 0x55 with 2 entries queued -> next cycle busy=0, fifo_count=0, out_valid=0; the following frame 0x81 is received correctly.
